// File: rtl/cam_ctrl_if.sv
// cam_ctrl_if: request/response handshake bundle between a requester and cam_ctrl
interface cam_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_hit;
   logic       rsp_dup;
   logic       rsp_err;
   logic [3:0] rsp_idx;
   modport master (
      output req_valid, req_op, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_hit, rsp_dup, rsp_err, rsp_idx
   );
   modport slave (
      input  req_valid, req_op, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_hit, rsp_dup, rsp_err, rsp_idx
   );
endinterface

// File: rtl/cam_ctrl.sv
// cam_ctrl: sequences search, insert and flush requests onto an external 16-entry CAM
module cam_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   cam_ctrl_if.slave  bus,
   output logic       full,
   output logic [4:0] count,
   output logic       cam_enable,
   output logic       cam_write,
   output logic [4:0] cam_addr,
   output logic [7:0] cam_data,
   input  logic [4:0] cam_out,
   input  logic       cam_found
);
   typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WRITE, FLUSH, RESP} state_t;
   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [7:0] key_q, key_d;
   logic [4:0] count_q, count_d;
   logic [3:0] fl_q, fl_d;
   logic [3:0] idx_q, idx_d;
   logic       hit_q, hit_d, dup_q, dup_d, err_q, err_d;
   logic       hit, resp, cam_out_unused;
   // entries at or above count are stale and must not report a hit
   assign hit = cam_found && ({1'b0, cam_out[3:0]} < count_q);
   assign cam_out_unused = cam_out[4];
   assign resp = state_q == RESP;
   assign full = count_q == 5'd16;
   assign count = count_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         key_q   <= '0;
         count_q <= '0;
         fl_q    <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         dup_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         key_q   <= key_d;
         count_q <= count_d;
         fl_q    <= fl_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         dup_q   <= dup_d;
         err_q   <= err_d;
      end
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      key_d   = key_q;
      count_d = count_q;
      fl_d    = fl_q;
      idx_d   = idx_q;
      hit_d   = hit_q;
      dup_d   = dup_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (bus.req_valid) begin
            op_d  = bus.req_op;
            key_d = bus.req_data;
            fl_d  = '0;
            idx_d = '0;
            hit_d = 1'b0;
            dup_d = 1'b0;
            err_d = bus.req_op == 2'b11 || (!bus.req_op[1] && bus.req_data == 8'h00);
            state_d = bus.req_op == 2'b10 ? FLUSH : err_d ? RESP : LOOKUP;
         end
         LOOKUP: state_d = CHECK;
         CHECK: begin
            state_d = RESP;
            if (hit) begin
               hit_d = 1'b1;
               dup_d = op_q == 2'b01;
               idx_d = cam_out[3:0];
            end else if (op_q == 2'b01) begin
               err_d   = full;
               state_d = full ? RESP : WRITE;
            end
         end
         WRITE: begin
            count_d = count_q + 5'd1;
            hit_d   = 1'b1;
            idx_d   = count_q[3:0];
            state_d = RESP;
         end
         FLUSH: begin
            fl_d = fl_q + 4'd1;
            if (fl_q == 4'd15) begin
               count_d = '0;
               state_d = RESP;
            end
         end
         RESP: if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.req_ready = state_q == IDLE;
      bus.rsp_valid = resp;
      bus.rsp_hit   = resp && hit_q;
      bus.rsp_dup   = resp && dup_q;
      bus.rsp_err   = resp && err_q;
      bus.rsp_idx   = resp ? idx_q : 4'd0;
      cam_enable    = state_q == LOOKUP;
      cam_write     = state_q == WRITE || state_q == FLUSH;
      cam_addr      = state_q == WRITE ? {1'b0, count_q[3:0]} : state_q == FLUSH ? {1'b0, fl_q} : 5'd0;
      cam_data      = (state_q == LOOKUP || state_q == CHECK || state_q == WRITE) ? key_q : 8'h00;
   end
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: vector table, corner sequences and randomized ops against a key-list model
module tb_cam_ctrl;
   typedef struct {
      logic [1:0] op;
      logic [7:0] key;
      logic       hit;
      logic       dup;
      logic       err;
      logic [3:0] idx;
      int         lat;
      int         wr;
      int         cnt;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       full, cam_enable, cam_write, cam_found;
   logic [4:0] count, cam_addr, cam_out;
   logic [7:0] cam_data;
   logic [7:0] mem [16];
   logic       poke_en = 1'b0;
   logic [3:0] poke_a = '0;
   logic [7:0] poke_d = '0;
   logic [4:0] wa[$];
   logic [7:0] wd[$];
   logic [7:0] en_key;
   logic [7:0] mdl[$];
   int         en_cnt = 0;
   int         tests = 0;
   int         fails = 0;
   vec_t       tbl[11];
   cam_ctrl_if bus ();
   cam_ctrl dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .full(full), .count(count),
      .cam_enable(cam_enable), .cam_write(cam_write), .cam_addr(cam_addr),
      .cam_data(cam_data), .cam_out(cam_out), .cam_found(cam_found)
   );
   always #5 clk = ~clk;
   // behavioural CAM: lowest matching slot wins, bit 4 of the result is noise
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         cam_found <= 1'b0;
         cam_out   <= '0;
      end else begin
         if (cam_write) mem[cam_addr[3:0]] <= cam_data;
         if (poke_en) mem[poke_a] <= poke_d;
         if (cam_enable) begin
            cam_found <= 1'b0;
            cam_out   <= {1'($urandom), 4'd0};
            for (int i = 15; i >= 0; i--)
               if (mem[i] == cam_data) begin
                  cam_found <= 1'b1;
                  cam_out   <= {1'($urandom), 4'(i)};
               end
         end
      end
   always @(posedge clk)
      if (rst_n) begin
         if (cam_write) begin
            wa.push_back(cam_addr);
            wd.push_back(cam_data);
         end
         if (cam_enable) begin
            en_cnt++;
            en_key = cam_data;
         end
         if (cam_enable && cam_write) begin
            tests++;
            fails++;
            $display("FAIL cam_excl: enable=%0d write=%0d required not both 1", cam_enable, cam_write);
         end
      end
   task automatic chk(input string n, input int a, input int e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask
   function automatic vec_t mk(int op, int key, int hit, int dup, int err, int idx, int lat, int wr, int cnt);
      vec_t v;
      v.op = 2'(op); v.key = 8'(key); v.hit = 1'(hit); v.dup = 1'(dup); v.err = 1'(err);
      v.idx = 4'(idx); v.lat = lat; v.wr = wr; v.cnt = cnt;
      return v;
   endfunction
   // reference model: the allocated keys in slot order, nothing more
   task automatic model(input int op, input int key, output vec_t v);
      int pos = -1;
      foreach (mdl[i]) if (mdl[i] == 8'(key)) pos = i;
      v = mk(op, key, 0, 0, 0, 0, 3, 0, 0);
      if (op == 2) begin
         mdl.delete();
         v.lat = 17;
         v.wr  = 16;
      end else if (op == 3 || key == 0) begin
         v.err = 1'b1;
         v.lat = 1;
      end else if (pos >= 0) begin
         v.hit = 1'b1;
         v.dup = op == 1;
         v.idx = 4'(pos);
      end else if (op == 1 && mdl.size() == 16) begin
         v.err = 1'b1;
      end else if (op == 1) begin
         v.hit = 1'b1;
         v.idx = 4'(mdl.size());
         mdl.push_back(8'(key));
         v.lat = 4;
         v.wr  = 1;
      end
      v.cnt = mdl.size();
   endtask
   task automatic run(input vec_t v, input int hold);
      int lat, w0, e0;
      bit look;
      @(negedge clk);
      bus.req_op    = v.op;
      bus.req_data  = v.key;
      bus.req_valid = 1'b1;
      chk("req_ready_idle", int'(bus.req_ready), 1);
      w0 = wa.size();
      e0 = en_cnt;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.rsp_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      chk("latency", lat, v.lat);
      chk("rsp_hit", int'(bus.rsp_hit), int'(v.hit));
      chk("rsp_dup", int'(bus.rsp_dup), int'(v.dup));
      chk("rsp_err", int'(bus.rsp_err), int'(v.err));
      chk("rsp_idx", int'(bus.rsp_idx), int'(v.idx));
      chk("count", int'(count), v.cnt);
      chk("full", int'(full), int'(v.cnt == 16));
      chk("writes", wa.size() - w0, v.wr);
      for (int i = 0; i < v.wr && w0 + i < wa.size(); i++) begin
         chk("waddr", int'(wa[w0+i]), v.wr == 16 ? i : int'(v.idx));
         chk("wdata", int'(wd[w0+i]), v.wr == 16 ? 0 : int'(v.key));
      end
      look = v.lat == 3 || v.lat == 4;
      chk("lookups", en_cnt - e0, int'(look));
      if (look && en_cnt > e0) chk("lookup_key", int'(en_key), int'(v.key));
      repeat (hold) begin
         @(negedge clk);
         chk("hold_valid", int'(bus.rsp_valid), 1);
         chk("hold_ready", int'(bus.req_ready), 0);
         chk("hold_rsp", int'({bus.rsp_hit, bus.rsp_dup, bus.rsp_err, bus.rsp_idx}),
             int'({v.hit, v.dup, v.err, v.idx}));
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("rsp_done", int'(bus.rsp_valid), 0);
      chk("rsp_zero", int'({bus.rsp_hit, bus.rsp_dup, bus.rsp_err, bus.rsp_idx}), 0);
      chk("req_ready_back", int'(bus.req_ready), 1);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mdl.delete();
   endtask
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t v;
      int r, op;
      bus.req_valid = 1'b0;
      bus.req_op    = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      tbl[0]  = mk(1, 8'hA5, 1, 0, 0, 0, 4, 1, 1);
      tbl[1]  = mk(0, 8'hA5, 1, 0, 0, 0, 3, 0, 1);
      tbl[2]  = mk(1, 8'hA5, 1, 1, 0, 0, 3, 0, 1);
      tbl[3]  = mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 1);
      tbl[4]  = mk(3, 8'h33, 0, 0, 1, 0, 1, 0, 1);
      tbl[5]  = mk(1, 8'h00, 0, 0, 1, 0, 1, 0, 1);
      tbl[6]  = mk(0, 8'h7E, 0, 0, 0, 0, 3, 0, 1);
      tbl[7]  = mk(1, 8'h7E, 1, 0, 0, 1, 4, 1, 2);
      tbl[8]  = mk(0, 8'h7E, 1, 0, 0, 1, 3, 0, 2);
      tbl[9]  = mk(2, 8'h00, 0, 0, 0, 0, 17, 16, 0);
      tbl[10] = mk(0, 8'hA5, 0, 0, 0, 0, 3, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst_req_ready", int'(bus.req_ready), 1);
      chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst_rsp", int'({bus.rsp_hit, bus.rsp_dup, bus.rsp_err, bus.rsp_idx}), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_cam", int'({cam_enable, cam_write, cam_addr, cam_data}), 0);
      rst_n = 1'b1;
      foreach (tbl[i]) run(tbl[i], 0);
      for (int k = 1; k <= 16; k++) run(mk(1, k, 1, 0, 0, k - 1, 4, 1, k), 0);
      run(mk(1, 8'h20, 0, 0, 1, 0, 3, 0, 16), 0);
      run(mk(0, 16, 1, 0, 0, 15, 3, 0, 16), 0);
      run(mk(0, 1, 1, 0, 0, 0, 3, 0, 16), 5);
      run(mk(2, 8'h5A, 0, 0, 0, 0, 17, 16, 0), 2);
      run(mk(1, 8'h11, 1, 0, 0, 0, 4, 1, 1), 0);
      @(negedge clk);
      bus.req_op    = 2'b10;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", int'(bus.req_ready), 1);
      chk("midrst_rsp_valid", int'(bus.rsp_valid), 0);
      chk("midrst_count", int'(count), 0);
      chk("midrst_cam", int'({cam_enable, cam_write, cam_addr, cam_data}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      mdl.delete();
      repeat (20) begin
         @(negedge clk);
         chk("midrst_no_rsp", int'(bus.rsp_valid), 0);
      end
      @(negedge clk);
      poke_en = 1'b1;
      poke_a  = 4'd5;
      poke_d  = 8'h42;
      @(posedge clk);
      #1 poke_en = 1'b0;
      run(mk(0, 8'h42, 0, 0, 0, 0, 3, 0, 0), 0);
      run(mk(1, 8'h42, 1, 0, 0, 0, 4, 1, 1), 0);
      run(mk(0, 8'h42, 1, 0, 0, 0, 3, 0, 1), 0);
      do_reset();
      for (int n = 0; n < 250; n++) begin
         r  = $urandom_range(0, 99);
         op = r < 45 ? 0 : r < 92 ? 1 : r < 96 ? 2 : 3;
         model(op, $urandom_range(0, 20), v);
         run(v, $urandom_range(0, 2));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cam_ctrl.md
CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: req_valid  in  1  request present; req_ready  out  1  controller can accept.
REQ-004 SHALL have ports: req_op  in  2  00 search, 01 insert, 10 flush, 11 reserved; req_data  in  8  key.
REQ-005 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_hit  out  1; rsp_dup  out  1; rsp_err  out  1; rsp_idx  out  4.
REQ-006 SHALL have ports: full  out  1  all 16 slots allocated; count  out  5  allocated slots, 0..16.
REQ-007 SHALL have CAM-side ports: cam_enable  out  1; cam_write  out  1; cam_addr  out  5 (bit 4 always 0); cam_data  out  8; cam_out  in  5; cam_found  in  1.

Function
REQ-008 SHALL implement states IDLE, LOOKUP, CHECK, WRITE, FLUSH, RESP; req_ready=1 only in IDLE.
REQ-009 SHALL register req_op/req_data on handshake (req_valid&&req_ready); cam_data SHALL drive the registered key, held unchanged through LOOKUP and CHECK.
REQ-010 SHALL, from IDLE, go to FLUSH for op 10, to RESP with rsp_err=1 for op 11 or for op 00/01 with key 8'h00, else to LOOKUP.
REQ-011 SHALL in LOOKUP drive cam_enable=1, cam_write=0 for exactly one cycle, then go to CHECK.
REQ-012 SHALL in CHECK drive cam_write=0, cam_enable=0; hit = cam_found && (cam_out[3:0] < count); capture cam_out[3:0] as idx.
REQ-013 SHALL, for search in CHECK, go to RESP with rsp_hit=hit, rsp_idx=idx if hit else 0.
REQ-014 SHALL, for insert in CHECK: hit -> RESP with rsp_hit=1, rsp_dup=1, rsp_idx=idx, no write; miss and full -> RESP with rsp_err=1, no write; miss and not full -> WRITE.
REQ-015 SHALL in WRITE drive cam_write=1, cam_addr={1'b0,count[3:0]}, cam_data=key for one cycle; count increments by 1; then RESP with rsp_hit=1, rsp_idx=old count[3:0].
REQ-016 SHALL in FLUSH write 8'h00 to cam_addr 0..15 on 16 consecutive cycles (cam_write=1), then set count=0 and go to RESP with all flags 0.
REQ-017 SHALL hold rsp_valid=1 and all rsp_* stable in RESP until rsp_ready=1; return to IDLE on that cycle.
REQ-018 SHALL drive rsp_hit/rsp_dup/rsp_err/rsp_idx to 0 when rsp_valid=0.
REQ-019 SHALL set full = (count==16); count SHALL never exceed 16 nor wrap.
REQ-020 SHALL drive cam_enable=0, cam_write=0 in IDLE and RESP; cam_enable and cam_write SHALL never both be 1.
REQ-021 SHALL give latency from handshake cycle T to rsp_valid: search/dup/full-error T+3, insert-write T+4, flush T+17, immediate error T+1.
REQ-022 SHALL ignore req_valid while not IDLE; no request queueing.

Reset
REQ-023 SHALL on rst_n=0 immediately enter IDLE: count=0, req_ready=1, rsp_valid=0, all rsp_* 0, cam_enable=0, cam_write=0, cam_addr=0, cam_data=0.
REQ-024 SHALL abandon any in-flight operation on reset mid-operation with no response issued; CAM contents are cleared by the CAM's own reset, consistent with count=0.

Verification
REQ-025 SHALL pass: reset, insert 8'hA5 -> rsp at T+4, rsp_hit=1, rsp_idx=0, count=1; search 8'hA5 -> T+3, rsp_hit=1, rsp_idx=0.
REQ-026 SHALL pass: insert 8'hA5 again -> rsp_dup=1, rsp_idx=0, count stays 1, no cam_write pulse.
REQ-027 SHALL pass: insert keys 1..16 -> rsp_idx 0..15, full=1; insert 8'h20 -> rsp_err=1, count=16.
REQ-028 SHALL pass: search 8'h00 or op 11 -> rsp_err=1 at T+1; search unknown 8'h7E -> rsp_hit=0, rsp_idx=0.
REQ-029 SHALL pass: flush -> 16 cam_write pulses on addr 0..15, rsp at T+17, count=0, full=0; prior key search then misses.
REQ-030 SHALL pass: hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0; assert rst_n=0 during FLUSH -> immediate IDLE, rsp_valid=0.
